pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
Output-side counterpart of the button debounce path. The debouncer turns a noisy level into a one-cycle pulse. This block turns one-cycle pulses back into clean, timed output levels: a fixed-width high window followed by a fixed low gap, suitable for an LED or buzzer. Pulses arriving while an output window is in progress are queued in a saturating pending counter, so every accepted press produces exactly one visible window.

Parameters:
HOLD, 8, number of Clk cycles S stays high per window (legal range 1..2^CNT_W-1)
GAP, 4, number of Clk cycles S stays low between consecutive windows (legal range 1..2^CNT_W-1)
CNT_W, 8, width of the internal cycle counter
PEND_MAX, 3, maximum number of queued pulses (legal range 1..2^PEND_W-1)
PEND_W, 2, width of the Pend output and pending counter

Ports:
Clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
Pulse  input  1  one-cycle request pulse, sampled on rising Clk
Clr  input  1  synchronous clear of Ovf (does not affect queue or FSM)
S  output  1  stretched output level, registered
Busy  output  1  high whenever FSM is not IDLE, registered
Pend  output  PEND_W  current pending-pulse count
Ovf  output  1  sticky flag, set when a pulse is dropped because the queue is full

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, counter=0, pending counter=0. All outputs are 0: S, Busy, Pend, Ovf.
- FSM states: IDLE, HOLD, GAP. S=1 only in HOLD. Busy=1 in HOLD and GAP.
- IDLE with Pulse=1: on the next edge go to HOLD, load the counter. S rises 1 cycle after the Pulse-sampling edge (latency 1). Pend is unchanged.
- HOLD lasts exactly HOLD cycles, then go to GAP. GAP lasts exactly GAP cycles.
- Last GAP cycle, pending>0: go to HOLD and decrement pending. S is low for exactly GAP cycles between windows.
- Last GAP cycle, pending=0, Pulse=0: go to IDLE.
- Last GAP cycle, pending=0, Pulse=1: go directly to HOLD. Pending stays 0 and the pulse is not queued.
- Pulse=1 in HOLD, or in GAP other than the consumption case above: increment pending.
  - If pending=PEND_MAX, pending holds at PEND_MAX and Ovf sets to 1 on the next edge.
- Last GAP cycle with pending>0 and Pulse=1 at the same time: consume one and add one, so pending is unchanged. Ovf is not set, even if pending=PEND_MAX.
- Ovf:
  - Ovf stays set until Clr=1.
  - Clr=1 clears Ovf on the next edge.
  - If Clr=1 and a drop event occur in the same cycle, the drop wins and Ovf=1.
- Pulse held high for multiple cycles counts as one pulse per cycle. Upstream must supply single-cycle pulses.
- rst asserted mid-window: S drops immediately (asynchronously) and the queue is discarded. After rst deasserts, operation resumes from IDLE.
- Counter arithmetic: the counter holds the remaining cycles and counts down. A state exits when the counter reaches 1. No wrap-around is possible within the legal parameter ranges.

Test Plan:
- Reset: hold rst=0 for 3 cycles with Pulse toggling -> S=0, Busy=0, Pend=0, Ovf=0 throughout. Release rst -> still idle.
- Single pulse (defaults), Pulse high at edge t -> S=1 for edges t+1..t+8, then S=0 with Busy=1 for t+9..t+12, then Busy=0 at t+13. Pend stays 0.
- Two pulses, second at t+3 (during HOLD) -> Pend=1 from t+4. First window t+1..t+8, gap t+9..t+12, second window t+13..t+20, Pend=0 from t+13, Busy=0 at t+25.
- Overflow: Pulse at t, then pulses at t+2, t+3, t+4, t+5 -> Pend saturates at 3, Ovf=1 from t+6. Exactly 4 windows total. Ovf stays 1 until Clr pulse, then 0 on the next edge.
- Simultaneous events:
  - With Pend=3, Pulse on the last GAP cycle -> Pend stays 3, Ovf stays 0.
  - Separately, with Pend=0, Pulse on the last GAP cycle -> next window starts on the following edge with no extra low gap, Pend=0.
- Reset mid-operation: assert rst during the 5th HOLD cycle with Pend=2 -> S, Busy, Pend drop to 0 immediately. A pulse after release produces exactly one window.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Turns single-cycle request pulses into timed output windows: HOLD cycles high, then GAP cycles low.
// Requests that arrive mid-window are queued in a saturating pending counter; a drop sets the sticky Ovf flag.
module pulse_stretcher #(
  parameter int HOLD     = 8,
  parameter int GAP      = 4,
  parameter int CNT_W    = 8,
  parameter int PEND_MAX = 3,
  parameter int PEND_W   = 2
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              Pulse,
  input  logic              Clr,
  output logic              S,
  output logic              Busy,
  output logic [PEND_W-1:0] Pend,
  output logic              Ovf
);

  // state   | meaning
  // IDLE    | no window active, waiting for a pulse
  // HOLD    | output high, counter holds remaining high cycles
  // GAP     | output low between windows, counter holds remaining low cycles
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PEND_W-1:0] pend, pend_nxt;
  logic              last_gap, pend_full, drop, ovf_nxt;

  assign last_gap  = (state == ST_GAP) && (cnt == CNT_ONE);
  assign pend_full = (pend == PEND_TOP);
  // The last GAP cycle either consumes the new pulse directly or trades it for a queued one, so it never drops.
  assign drop      = Pulse && pend_full &&
                     ((state == ST_HOLD) || ((state == ST_GAP) && !last_gap));
  assign ovf_nxt   = drop ? 1'b1 : (Clr ? 1'b0 : Ovf);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    case (state)
      ST_IDLE: begin
        if (Pulse) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt == CNT_ONE) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
        if (Pulse && !pend_full) pend_nxt = pend + PEND_ONE;
      end
      ST_GAP: begin
        if (cnt == CNT_ONE) begin
          if (pend != '0) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LD;
            if (!Pulse) pend_nxt = pend - PEND_ONE;
          end else if (Pulse) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LD;
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
          if (Pulse && !pend_full) pend_nxt = pend + PEND_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= '0;
      Ovf   <= 1'b0;
      S     <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      Ovf   <= ovf_nxt;
      S     <= (state_nxt == ST_HOLD);
      Busy  <= (state_nxt != ST_IDLE);
    end
  end

  assign Pend = pend;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios with literal expectations plus a randomized run,
// every cycle compared against a window/position model of the output sequence.
module tb_pulse_stretcher;
  localparam int HOLD = 8, GAP = 4, CNT_W = 8, PEND_MAX = 3, PEND_W = 2;
  localparam int PERIOD = HOLD + GAP;

  logic              Clk = 1'b0;
  logic              rst = 1'b1;
  logic              Pulse = 1'b0;
  logic              Clr = 1'b0;
  logic              S, Busy, Ovf;
  logic [PEND_W-1:0] Pend;

  int n_tests = 0;
  int n_fail  = 0;

  pulse_stretcher #(.HOLD(HOLD), .GAP(GAP), .CNT_W(CNT_W), .PEND_MAX(PEND_MAX), .PEND_W(PEND_W)) dut (
    .Clk(Clk), .rst(rst), .Pulse(Pulse), .Clr(Clr),
    .S(S), .Busy(Busy), .Pend(Pend), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  // Model: a window occupies PERIOD cycles; m_pos is the cycle index inside it (high while < HOLD).
  int m_busy = 0, m_pos = 0, m_pend = 0, m_ovf = 0;

  always @(posedge Clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_pos = 0; m_pend = 0; m_ovf = 0;
    end else begin
      int drop;
      drop = 0;
      if (m_busy == 0) begin
        if (Pulse) begin m_busy = 1; m_pos = 0; end
      end else if (m_pos == PERIOD - 1) begin
        if (m_pend > 0) begin
          m_pos = 0;
          if (!Pulse) m_pend = m_pend - 1;
        end else if (Pulse) m_pos = 0;
        else m_busy = 0;
      end else begin
        m_pos = m_pos + 1;
        if (Pulse) begin
          if (m_pend == PEND_MAX) drop = 1;
          else m_pend = m_pend + 1;
        end
      end
      if (drop) m_ovf = 1;
      else if (Clr) m_ovf = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    chk("model_S",    int'(S),    (m_busy != 0 && m_pos < HOLD) ? 1 : 0);
    chk("model_Busy", int'(Busy), m_busy);
    chk("model_Pend", int'(Pend), m_pend);
    chk("model_Ovf",  int'(Ovf),  m_ovf);
  end

  int rises;
  logic s_prev;

  task automatic drain();
    for (int i = 0; i < 6 * PERIOD && Busy; i++) @(negedge Clk);
    chk("drain_idle", int'(Busy), 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    // Reset held with Pulse toggling
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      Pulse = ~Pulse;
      chk("rst_S", int'(S), 0); chk("rst_Busy", int'(Busy), 0);
      chk("rst_Pend", int'(Pend), 0); chk("rst_Ovf", int'(Ovf), 0);
    end
    @(negedge Clk); Pulse = 1'b0; rst = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("idle_after_rst", int'({S, Busy, Pend, Ovf}), 0);

    // Single pulse
    Pulse = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge Clk); Pulse = 1'b0;
      chk("single_S", int'(S), (k <= 8) ? 1 : 0);
      chk("single_Busy", int'(Busy), (k <= 12) ? 1 : 0);
      chk("single_Pend", int'(Pend), 0);
    end

    // Two pulses, second during HOLD
    Pulse = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge Clk); Pulse = (k == 3);
      chk("two_S", int'(S), ((k <= 8) || (k >= 13 && k <= 20)) ? 1 : 0);
      chk("two_Pend", int'(Pend), (k >= 4 && k <= 12) ? 1 : 0);
      chk("two_Busy", int'(Busy), (k <= 24) ? 1 : 0);
    end

    // Overflow: pulses at 0,2,3,4,5 -> 4 windows, Ovf sticky until Clr
    Pulse = 1'b1; rises = 0; s_prev = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge Clk); Pulse = (k >= 2 && k <= 5);
      if (S && !s_prev) rises++;
      s_prev = S;
      if (k == 5) begin chk("ovf_pend3", int'(Pend), 3); chk("ovf_pre", int'(Ovf), 0); end
      if (k == 6) chk("ovf_set", int'(Ovf), 1);
    end
    chk("ovf_windows", rises, 4);
    chk("ovf_idle", int'(Busy), 0);
    chk("ovf_sticky", int'(Ovf), 1);
    Clr = 1'b1;
    @(negedge Clk); Clr = 1'b0;
    chk("ovf_clr", int'(Ovf), 0);

    // Pend=3 with pulse on last GAP cycle
    Pulse = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge Clk); Pulse = (k <= 3) || (k == 12);
      if (k == 12) chk("full_last_gap_pend", int'(Pend), 3);
    end
    chk("full_sim_pend", int'(Pend), 3);
    chk("full_sim_ovf", int'(Ovf), 0);
    chk("full_sim_S", int'(S), 1);
    drain();

    // Pend=0 with pulse on last GAP cycle: back-to-back window
    @(negedge Clk); Pulse = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge Clk); Pulse = (k == 12);
      chk("b2b_S", int'(S), ((k <= 8) || (k >= 13 && k <= 20)) ? 1 : 0);
      chk("b2b_Busy", int'(Busy), (k <= 24) ? 1 : 0);
      chk("b2b_Pend", int'(Pend), 0);
    end

    // Reset during 5th HOLD cycle with Pend=2
    Pulse = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk); Pulse = (k == 2 || k == 3);
    end
    chk("mid_pre_pend", int'(Pend), 2);
    chk("mid_pre_S", int'(S), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_S", int'(S), 0); chk("mid_rst_Busy", int'(Busy), 0);
    chk("mid_rst_Pend", int'(Pend), 0);
    @(negedge Clk); @(negedge Clk); rst = 1'b1;
    @(negedge Clk); Pulse = 1'b1; rises = 0; s_prev = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk); Pulse = 1'b0;
      if (S && !s_prev) rises++;
      s_prev = S;
    end
    chk("post_rst_windows", rises, 1);
    chk("post_rst_idle", int'(Busy), 0);

    // Randomized traffic, checked every cycle by the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge Clk);
      Pulse = ($urandom_range(0, 5) == 0);
      Clr   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        @(negedge Clk); #2 rst = 1'b1;
      end
    end
    @(negedge Clk); Pulse = 1'b0; Clr = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
